picorv32_axi_ram_responder: RTL and testbench
=============================================

# picorv32_axi_ram_responder

AXI4-lite responder (slave) memory answering the `mem_axi_*` master port of the PicoRV32 AXI core. It holds a single-clock word RAM with independent write and read channels, byte-strobe writes, registered reads, and optional injected wait states. It serves as program and data memory in simulation and FPGA test systems. There are no response-code signals on this interface, so an out-of-range access completes normally and raises a sticky flag.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; must be a power of two, ≥2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be aligned to `MEM_WORDS*4`.
- `WAIT_CYCLES`, 0: cycles a valid must be held before the matching ready asserts; range 0..15.
- `INIT_FILE`, "": if non-empty, the RAM is preloaded with `$readmemh` at elaboration.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mem_axi_awvalid` in 1 / `mem_axi_awready` out 1 / `mem_axi_awaddr` in 32 / `mem_axi_awprot` in 3: write address channel; prot is ignored.
- `mem_axi_wvalid` in 1 / `mem_axi_wready` out 1 / `mem_axi_wdata` in 32 / `mem_axi_wstrb` in 4: write data channel.
- `mem_axi_bvalid` out 1 / `mem_axi_bready` in 1: write response.
- `mem_axi_arvalid` in 1 / `mem_axi_arready` out 1 / `mem_axi_araddr` in 32 / `mem_axi_arprot` in 3: read address channel; prot is ignored.
- `mem_axi_rvalid` out 1 / `mem_axi_rready` in 1 / `mem_axi_rdata` out 32: read data channel.
- `oob` out 1: sticky flag, set by any out-of-range access.

## Operation
- Address decode: `off = addr - BASE_ADDR`. The access is in range iff `off < MEM_WORDS*4`. Word index = `off[2 +: log2(MEM_WORDS)]`. `addr[1:0]` is ignored.
- Write path FSM, states `W_IDLE`, `W_RESP`:
  - In `W_IDLE`, AW and W are accepted independently. Each has a one-entry holding register (`aw_held`, `w_held`).
  - `awready = W_IDLE & !aw_held & aw_wait_done`.
  - `wready = W_IDLE & !w_held & w_wait_done`.
  - On the edge where the second of the two handshakes completes (or both complete together), the RAM is written and the FSM enters `W_RESP`. The RAM uses the held or incoming address/data as applicable.
  - Bytes are written only where `wstrb[i]`=1; `wstrb`=0 writes nothing but still responds.
  - Out-of-range writes are dropped and set `oob`.
  - `W_RESP`: `bvalid`=1 until `bready`, then return to `W_IDLE` and clear both held flags.
- Read path FSM, states `R_IDLE`, `R_FETCH`, `R_RESP`:
  - `arready = R_IDLE & ar_wait_done`.
  - AR handshake: latch the word index and in-range bit, then enter `R_FETCH`.
  - `R_FETCH`: the RAM is read synchronously into the `rdata` register (32'h0 if out of range, which also sets `oob`), then enter `R_RESP`.
  - `R_RESP`: `rvalid`=1 and `rdata` is held stable until `rready`, then return to `R_IDLE`.
- Wait counters: there is one 4-bit counter per address/data channel.
  - It increments while valid=1 and ready=0, saturating at `WAIT_CYCLES`.
  - It clears on handshake.
  - `*_wait_done = (cnt == WAIT_CYCLES)`. With `WAIT_CYCLES`=0, ready depends only on state.
- The write and read paths are fully concurrent; the RAM has one write port and one read port.
- Same-word collision: a read whose `R_FETCH` cycle coincides with the write edge returns the old data. A read fetched one or more cycles after the write edge returns the new data.

## Timing
- Reset values:
  - `awready`, `wready`, `arready` = 1 if `WAIT_CYCLES`=0, else 0.
  - `bvalid`=0, `rvalid`=0, `rdata`=0, `oob`=0.
  - Both FSMs go to idle; held flags and counters clear; RAM contents are not reset.
- Write latency: last of the AW/W handshakes at edge k → `bvalid`=1 in the cycle after edge k. Best-case throughput is one write every 2 cycles.
- Read latency: AR handshake at edge k → `R_FETCH` after k → `rvalid`=1 after edge k+1. Best-case throughput is one read every 3 cycles.
- `bvalid` and `rvalid` never drop without the matching ready. Ready signals never depend combinationally on `bready` or `rready`.
- Reset asserted mid-transaction aborts it immediately. A write whose commit edge has not occurred leaves the RAM unmodified.
- `oob` sets on the AW/W commit edge (write) or the `R_FETCH` edge (read). It clears only on reset.

## Test plan
- Write 32'hDEADBEEF to 0x10 with `wstrb`=4'hF (AW and W in the same cycle), then read 0x10 → `bvalid` one cycle after the handshake; `rvalid` 2 cycles after AR; `rdata`=32'hDEADBEEF.
- W issued 3 cycles before AW, with `wstrb`=4'b0101 and data 32'h11223344 over 32'hFFFFFFFF → held W is used; readback is 32'hFF22FF44; `wready`=0 while W is held.
- `bready`/`rready` held low for 5 cycles → `bvalid`/`rvalid` and `rdata` stay stable; `awready`/`arready` stay 0 until the response handshake.
- `WAIT_CYCLES`=3 → each ready asserts exactly 3 cycles after its valid rises; data remains correct.
- Read at `BASE_ADDR + MEM_WORDS*4` → `rdata`=0 and `oob`=1. Write to the same address → no RAM change, `bvalid` still asserts.
- Write word 5 and read word 5 concurrently with `R_FETCH` on the write edge → old value returned; repeating the read returns the new value. Reset asserted mid-read → `rvalid`=0 and `arready` restored.

Source files
------------

// File: rtl/picorv32_axi_ram_responder_if.sv
// AXI4-lite bus bundle between the PicoRV32 mem_axi master and the RAM responder.
interface picorv32_axi_ram_responder_if;
    logic        mem_axi_awvalid;
    logic        mem_axi_awready;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;

    logic        mem_axi_wvalid;
    logic        mem_axi_wready;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;

    logic        mem_axi_bvalid;
    logic        mem_axi_bready;

    logic        mem_axi_arvalid;
    logic        mem_axi_arready;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;

    logic        mem_axi_rvalid;
    logic        mem_axi_rready;
    logic [31:0] mem_axi_rdata;

    modport master (
        output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        output mem_axi_bready,
        output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        output mem_axi_rready,
        input  mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
        input  mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
    );

    modport slave (
        input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        input  mem_axi_bready,
        input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        input  mem_axi_rready,
        output mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
        output mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
    );
endinterface

// File: rtl/picorv32_axi_ram_responder.sv
// AXI4-lite word RAM responder for the PicoRV32 mem_axi port.
// Independent write (AW/W/B) and read (AR/R) paths, byte-strobe writes,
// registered reads, optional wait states and a sticky out-of-range flag.
module picorv32_axi_ram_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic                               clk,
    input  logic                               reset,
    picorv32_axi_ram_responder_if.slave        bus,
    output logic                               oob
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
    localparam logic [3:0]  WAIT_LIM  = 4'(WAIT_CYCLES);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_t;

    logic [31:0] mem [MEM_WORDS];

    function automatic logic in_range(input logic [31:0] addr);
        return {1'b0, addr - BASE_ADDR} < MEM_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    // Wait counter: count stalled valid cycles up to the limit, clear on handshake
    function automatic logic [3:0] next_cnt(input logic [3:0] cnt, input logic valid,
                                            input logic ready);
        if (valid && ready)                 return 4'd0;
        else if (valid && cnt != WAIT_LIM)  return cnt + 4'd1;
        else                                return cnt;
    endfunction

    // prot carries no meaning for a plain RAM
    logic unused_prot;
    assign unused_prot = ^{bus.mem_axi_awprot, bus.mem_axi_arprot};

    w_state_t    w_state, w_state_next;
    r_state_t    r_state, r_state_next;
    logic        aw_held, w_held;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic [3:0]  aw_cnt, w_cnt, ar_cnt;
    logic        aw_ready, w_ready, ar_ready, b_valid, r_valid;
    logic        aw_hs, w_hs, ar_hs, commit;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic        wr_in_range;
    logic [IDX_W-1:0] r_idx;
    logic        r_in_range;
    logic [31:0] rdata;

    assign bus.mem_axi_awready = aw_ready;
    assign bus.mem_axi_wready  = w_ready;
    assign bus.mem_axi_bvalid  = b_valid;
    assign bus.mem_axi_arready = ar_ready;
    assign bus.mem_axi_rvalid  = r_valid;
    assign bus.mem_axi_rdata   = rdata;

    // Write path: readies, handshakes and commit once both AW and W are present
    always_comb begin
        w_state_next = w_state;
        aw_ready     = 1'b0;
        w_ready      = 1'b0;
        b_valid      = 1'b0;
        aw_hs        = 1'b0;
        w_hs         = 1'b0;
        commit       = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_ready = !aw_held && (aw_cnt == WAIT_LIM);
                w_ready  = !w_held && (w_cnt == WAIT_LIM);
                aw_hs    = bus.mem_axi_awvalid && aw_ready;
                w_hs     = bus.mem_axi_wvalid && w_ready;
                if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (bus.mem_axi_bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Commit uses whichever of held or incoming address/data is current
    always_comb begin
        wr_addr     = aw_hs ? bus.mem_axi_awaddr : aw_addr_q;
        wr_data     = w_hs ? bus.mem_axi_wdata : w_data_q;
        wr_strb     = w_hs ? bus.mem_axi_wstrb : w_strb_q;
        wr_in_range = in_range(wr_addr);
    end

    // Write FSM state and holding flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            w_state <= w_state_next;
            if (w_state == W_RESP && bus.mem_axi_bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
            end
        end
    end

    // Holding registers capture the early-arriving channel
    always_ff @(posedge clk) begin
        if (aw_hs) aw_addr_q <= bus.mem_axi_awaddr;
        if (w_hs) begin
            w_data_q <= bus.mem_axi_wdata;
            w_strb_q <= bus.mem_axi_wstrb;
        end
    end

    // RAM write port; reset blocks a commit that has not yet happened
    always_ff @(posedge clk) begin
        if (commit && wr_in_range && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[word_index(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Read path: accept AR, fetch one cycle, then present data until rready
    always_comb begin
        r_state_next = r_state;
        ar_ready     = 1'b0;
        r_valid      = 1'b0;
        ar_hs        = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_ready = (ar_cnt == WAIT_LIM);
                ar_hs    = bus.mem_axi_arvalid && ar_ready;
                if (ar_hs) r_state_next = R_FETCH;
            end
            R_FETCH: r_state_next = R_RESP;
            R_RESP: begin
                r_valid = 1'b1;
                if (bus.mem_axi_rready) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read FSM state, latched range bit and read data register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= R_IDLE;
            r_in_range <= 1'b0;
            rdata      <= 32'h0;
        end else begin
            r_state <= r_state_next;
            if (ar_hs) r_in_range <= in_range(bus.mem_axi_araddr);
            if (r_state == R_FETCH) rdata <= r_in_range ? mem[r_idx] : 32'h0;
        end
    end

    // Latched read word index
    always_ff @(posedge clk) begin
        if (ar_hs) r_idx <= word_index(bus.mem_axi_araddr);
    end

    // Per-channel wait-state counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_cnt <= 4'd0;
            w_cnt  <= 4'd0;
            ar_cnt <= 4'd0;
        end else begin
            aw_cnt <= next_cnt(aw_cnt, bus.mem_axi_awvalid, aw_ready);
            w_cnt  <= next_cnt(w_cnt, bus.mem_axi_wvalid, w_ready);
            ar_cnt <= next_cnt(ar_cnt, bus.mem_axi_arvalid, ar_ready);
        end
    end

    // Sticky out-of-range flag, set on write commit or read fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oob <= 1'b0;
        end else if ((commit && !wr_in_range) || (r_state == R_FETCH && !r_in_range)) begin
            oob <= 1'b1;
        end
    end

endmodule

// File: tb/tb_picorv32_axi_ram_responder.sv
// Directed bench for the AXI4-lite RAM responder (zero-wait and 3-wait instances).
module tb_picorv32_axi_ram_responder;

    logic clk = 1'b0;
    logic reset;
    logic oob, oob3;
    int   n_checks = 0;
    int   n_errors = 0;

    picorv32_axi_ram_responder_if bus ();
    picorv32_axi_ram_responder_if bus3 ();

    picorv32_axi_ram_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut (
        .clk(clk), .reset(reset), .bus(bus), .oob(oob)
    );

    picorv32_axi_ram_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3), .oob(oob3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hold);
        logic aw_now, w_now;
        int g;
        g = 0;
        bus.mem_axi_awvalid = 1'b1;
        bus.mem_axi_awaddr  = a;
        bus.mem_axi_wvalid  = 1'b1;
        bus.mem_axi_wdata   = d;
        bus.mem_axi_wstrb   = s;
        while ((bus.mem_axi_awvalid || bus.mem_axi_wvalid) && g < 20) begin
            aw_now = bus.mem_axi_awvalid && bus.mem_axi_awready;
            w_now  = bus.mem_axi_wvalid && bus.mem_axi_wready;
            step();
            if (aw_now) bus.mem_axi_awvalid = 1'b0;
            if (w_now)  bus.mem_axi_wvalid  = 1'b0;
            g++;
        end
        bus.mem_axi_awvalid = 1'b0;
        bus.mem_axi_wvalid  = 1'b0;
        check("wr_bvalid_latency", bus.mem_axi_bvalid, 1'b1);
        for (int i = 0; i < hold; i++) begin
            step();
            check("wr_bvalid_stall", bus.mem_axi_bvalid, 1'b1);
            check("wr_awready_stall", bus.mem_axi_awready, 1'b0);
        end
        bus.mem_axi_bready = 1'b1;
        step();
        bus.mem_axi_bready = 1'b0;
        check("wr_bvalid_drop", bus.mem_axi_bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] exp, input int hold);
        int g;
        g = 0;
        bus.mem_axi_arvalid = 1'b1;
        bus.mem_axi_araddr  = a;
        while (!bus.mem_axi_arready && g < 20) begin
            step();
            g++;
        end
        step();
        bus.mem_axi_arvalid = 1'b0;
        check("rd_fetch_rvalid", bus.mem_axi_rvalid, 1'b0);
        step();
        check("rd_rvalid_latency", bus.mem_axi_rvalid, 1'b1);
        check("rd_data", bus.mem_axi_rdata, exp);
        for (int i = 0; i < hold; i++) begin
            step();
            check("rd_rvalid_stall", bus.mem_axi_rvalid, 1'b1);
            check("rd_rdata_stall", bus.mem_axi_rdata, exp);
            check("rd_arready_stall", bus.mem_axi_arready, 1'b0);
        end
        bus.mem_axi_rready = 1'b1;
        step();
        bus.mem_axi_rready = 1'b0;
        check("rd_rvalid_drop", bus.mem_axi_rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1;
        bus.mem_axi_awvalid = 0; bus.mem_axi_awaddr = 0; bus.mem_axi_awprot = 0;
        bus.mem_axi_wvalid = 0; bus.mem_axi_wdata = 0; bus.mem_axi_wstrb = 0;
        bus.mem_axi_bready = 0; bus.mem_axi_arvalid = 0; bus.mem_axi_araddr = 0;
        bus.mem_axi_arprot = 0; bus.mem_axi_rready = 0;
        bus3.mem_axi_awvalid = 0; bus3.mem_axi_awaddr = 0; bus3.mem_axi_awprot = 0;
        bus3.mem_axi_wvalid = 0; bus3.mem_axi_wdata = 0; bus3.mem_axi_wstrb = 0;
        bus3.mem_axi_bready = 0; bus3.mem_axi_arvalid = 0; bus3.mem_axi_araddr = 0;
        bus3.mem_axi_arprot = 0; bus3.mem_axi_rready = 0;
        step();
        step();

        check("rst_awready", bus.mem_axi_awready, 1'b1);
        check("rst_wready", bus.mem_axi_wready, 1'b1);
        check("rst_arready", bus.mem_axi_arready, 1'b1);
        check("rst_bvalid", bus.mem_axi_bvalid, 1'b0);
        check("rst_rvalid", bus.mem_axi_rvalid, 1'b0);
        check("rst_rdata", bus.mem_axi_rdata, 32'h0);
        check("rst_oob", oob, 1'b0);
        check("rst3_awready", bus3.mem_axi_awready, 1'b0);
        check("rst3_wready", bus3.mem_axi_wready, 1'b0);
        check("rst3_arready", bus3.mem_axi_arready, 1'b0);
        reset = 1'b0;
        step();

        // Full-word write then read
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0);
        axi_read(32'h10, 32'hDEADBEEF, 0);

        // W arrives 3 cycles before AW with partial strobes
        axi_write(32'h20, 32'hFFFFFFFF, 4'hF, 0);
        bus.mem_axi_wvalid = 1'b1;
        bus.mem_axi_wdata  = 32'h11223344;
        bus.mem_axi_wstrb  = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.mem_axi_wvalid = 1'b0;
            check("held_wready", bus.mem_axi_wready, 1'b0);
            check("held_bvalid", bus.mem_axi_bvalid, 1'b0);
        end
        bus.mem_axi_awvalid = 1'b1;
        bus.mem_axi_awaddr  = 32'h20;
        check("held_awready", bus.mem_axi_awready, 1'b1);
        step();
        bus.mem_axi_awvalid = 1'b0;
        check("held_bvalid_commit", bus.mem_axi_bvalid, 1'b1);
        bus.mem_axi_bready = 1'b1;
        step();
        bus.mem_axi_bready = 1'b0;
        axi_read(32'h20, 32'hFF22FF44, 0);

        // Response back-pressure
        axi_write(32'h30, 32'hA5A5A5A5, 4'hF, 5);
        axi_read(32'h30, 32'hA5A5A5A5, 5);

        // Out-of-range accesses
        axi_write(32'h0, 32'hCAFEF00D, 4'hF, 0);
        check("oob_before", oob, 1'b0);
        axi_write(32'h1000, 32'h12345678, 4'hF, 0);
        check("oob_after_write", oob, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("oob_cleared", oob, 1'b0);
        axi_read(32'h0, 32'hCAFEF00D, 0);
        axi_read(32'h1000, 32'h0, 0);
        check("oob_after_read", oob, 1'b1);

        // Same-word collision: fetch edge equals write commit edge
        axi_write(32'h14, 32'h55555555, 4'hF, 0);
        bus.mem_axi_arvalid = 1'b1;
        bus.mem_axi_araddr  = 32'h14;
        step();
        bus.mem_axi_arvalid = 1'b0;
        bus.mem_axi_awvalid = 1'b1;
        bus.mem_axi_awaddr  = 32'h14;
        bus.mem_axi_wvalid  = 1'b1;
        bus.mem_axi_wdata   = 32'h66666666;
        bus.mem_axi_wstrb   = 4'hF;
        step();
        bus.mem_axi_awvalid = 1'b0;
        bus.mem_axi_wvalid  = 1'b0;
        check("coll_bvalid", bus.mem_axi_bvalid, 1'b1);
        check("coll_rvalid", bus.mem_axi_rvalid, 1'b1);
        check("coll_old_data", bus.mem_axi_rdata, 32'h55555555);
        bus.mem_axi_bready = 1'b1;
        bus.mem_axi_rready = 1'b1;
        step();
        bus.mem_axi_bready = 1'b0;
        bus.mem_axi_rready = 1'b0;
        axi_read(32'h14, 32'h66666666, 0);

        // Reset during a read fetch with a W held but never committed
        bus.mem_axi_arvalid = 1'b1;
        bus.mem_axi_araddr  = 32'h10;
        bus.mem_axi_wvalid  = 1'b1;
        bus.mem_axi_wdata   = 32'h0;
        bus.mem_axi_wstrb   = 4'hF;
        step();
        bus.mem_axi_arvalid = 1'b0;
        bus.mem_axi_wvalid  = 1'b0;
        check("midrst_arready_busy", bus.mem_axi_arready, 1'b0);
        check("midrst_wready_held", bus.mem_axi_wready, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_rvalid", bus.mem_axi_rvalid, 1'b0);
        check("midrst_arready", bus.mem_axi_arready, 1'b1);
        check("midrst_wready", bus.mem_axi_wready, 1'b1);
        step();
        reset = 1'b0;
        step();
        axi_read(32'h10, 32'hDEADBEEF, 0);

        // Three wait states on every channel
        bus3.mem_axi_awvalid = 1'b1;
        bus3.mem_axi_awaddr  = 32'h40;
        bus3.mem_axi_wvalid  = 1'b1;
        bus3.mem_axi_wdata   = 32'h0BADCAFE;
        bus3.mem_axi_wstrb   = 4'hF;
        n = 0;
        while (!bus3.mem_axi_awready && n < 20) begin
            step();
            n++;
        end
        check("w3_aw_wait", n, 3);
        check("w3_wready", bus3.mem_axi_wready, 1'b1);
        step();
        bus3.mem_axi_awvalid = 1'b0;
        bus3.mem_axi_wvalid  = 1'b0;
        check("w3_bvalid", bus3.mem_axi_bvalid, 1'b1);
        bus3.mem_axi_bready = 1'b1;
        step();
        bus3.mem_axi_bready = 1'b0;
        bus3.mem_axi_arvalid = 1'b1;
        bus3.mem_axi_araddr  = 32'h40;
        n = 0;
        while (!bus3.mem_axi_arready && n < 20) begin
            step();
            n++;
        end
        check("w3_ar_wait", n, 3);
        step();
        bus3.mem_axi_arvalid = 1'b0;
        step();
        check("w3_rvalid", bus3.mem_axi_rvalid, 1'b1);
        check("w3_rdata", bus3.mem_axi_rdata, 32'h0BADCAFE);
        bus3.mem_axi_rready = 1'b1;
        step();
        bus3.mem_axi_rready = 1'b0;
        check("w3_rvalid_drop", bus3.mem_axi_rvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
